lynx_reset_sequencer: RTL and testbench
=======================================

// Module: lynx_reset_sequencer
// PURPOSE
//  Parametrised reset controller for the Lynx core top level. It gathers N reset requests, PLL lock
//  and machine-mode changes, and synchronises the asynchronous inputs. It stretches the reset to a
//  minimum width, then releases NSTAGE reset domains in a fixed order with a gap between each
//  (e.g. stage 0 = SDRAM controller, stage 1 = lynx48 core/video). It also keeps a sticky
//  per-cause record for the OSD/debug.
// PARAMETERS
//  NSRC        3   number of level-sensitive reset request inputs (OSD reset, button, top RESET)
//  MODE_W      2   width of machine-mode word watched for changes
//  SYNC_STAGES 2   flops in each input synchroniser (>=2)
//  STRETCH     16  min cycles from last request drop to stage-0 release (>=1)
//  NSTAGE      2   number of staged reset outputs (>=1)
//  STAGE_GAP   8   cycles between consecutive stage releases (>=1)
// PORTS
//  clk_sys     in   1            system clock; all logic on rising edge
//  reset_n     in   1            synchronous, active-low global reset
//  pll_locked  in   1            async; low = request reset
//  req         in   NSRC         async level requests, active-high
//  mode        in   MODE_W       sync to clk_sys; any change requests reset
//  mode_chg_en in   1            1 = mode change triggers reset
//  rst_out     out  NSTAGE       per-domain reset, active-high; bit k released k-th
//  busy        out  1            1 while any rst_out bit is high
//  cause       out  NSRC+2       sticky: [NSRC-1:0]=req, [NSRC]=pll unlock, [NSRC+1]=mode change
//  cause_clr   in   1            sync pulse, clears cause
// BEHAVIOUR
//  - reset_n low at edge: state=HOLD, rst_out=all 1, busy=1, cause=0, cnt=0, stage idx=0.
//    Sync flops clear to 0 (pll path reads unlocked). mode_q<=mode, so there is no mode event on exit.
//  - Sync: pll_locked and each req bit pass through SYNC_STAGES flops -> pll_s, req_s.
//  - mode_evt = mode_chg_en & (mode != mode_q). mode_q<=mode every cycle. The event is 1 cycle wide.
//  - any_req = |req_s | ~pll_s | mode_evt.
//  - FSM (registered outputs; rst_out/busy update on the edge that changes state):
//    HOLD:    rst_out=all 1. While any_req: stay. At the edge where any_req=0: go STRETCH, cnt=1.
//    STRETCH: if any_req -> HOLD. Else if cnt==STRETCH: go RELEASE and clear rst_out[0].
//             If NSTAGE==1, go RUN instead. Otherwise cnt++.
//    RELEASE: if any_req -> HOLD with all rst_out set. Else count STAGE_GAP cycles, then clear
//             the next stage bit. After rst_out[NSTAGE-1] clears -> RUN.
//    RUN:     rst_out=0, busy=0. any_req -> HOLD.
//  - Timing: let T = first cycle HOLD sees any_req=0.
//    rst_out[k] falls at edge T+STRETCH+k*STAGE_GAP.
//    busy falls with rst_out[NSTAGE-1]; busy == |rst_out always.
//  - Assertion latency: a req/pll edge reaches rst_out high SYNC_STAGES+1 edges later.
//    A mode change reaches it 2 edges after the mode input changes.
//  - Re-entry is unconditional: a request in STRETCH/RELEASE/RUN sets every rst_out bit on the next
//    edge and restarts the full stretch. Already-released stages re-assert; there is no partial release.
//  - Release order is strictly ascending. A higher bit never clears before a lower bit.
//  - cause: each bit ORs in its sync'd source every cycle (pll bit = ~pll_s, mode bit = mode_evt).
//    On cause_clr the register clears, but active sources in the same cycle stay set (set wins).
//    cause is unaffected by the FSM. Only reset_n and cause_clr clear it.
//  - Counters are sized $clog2(max(STRETCH,STAGE_GAP)+1) and never wrap. cnt reloads on each state entry.
//  - The block adds no combinational path from inputs to outputs.
// TESTING
//  1 Reset: reset_n=0 3 cycles, pll_locked=1, req=0 -> during: rst_out=2'b11, busy=1, cause=0;
//    after release: rst_out[0] falls 16+SYNC cycles later, rst_out[1] 8 cycles after that.
//  2 Button: req[1] high 5 cycles in RUN -> rst_out=2'b11 three edges after the rise; cause[1]=1;
//    release is 16 cycles after sync'd drop (stage 0), then +8 (stage 1).
//  3 Mode change: mode 0->2 in RUN, mode_chg_en=1 -> rst_out=11 for 17 cycles then staged release;
//    cause[NSRC+1]=1. Repeat with mode_chg_en=0 -> no reset, cause unchanged.
//  4 Re-entry: pulse req[0] 1 cycle after rst_out[0] released (stage 1 still high)
//    -> both bits high on next sync'd edge; full 16+8 sequence restarts.
//  5 PLL loss: pll_locked low 100 cycles -> rst_out held 11 throughout; cause[NSRC]=1;
//    cause_clr while low -> bit stays 1; cause_clr after recovery -> bit 0.
//  6 Mid-operation reset_n: assert reset_n=0 in STRETCH with cnt=9 -> next edge HOLD, cnt=0,
//    cause=0; after reset_n=1, the sequence is as in test 1.

Source files
------------

// File: rtl/lynx_reset_sequencer_if.sv
// Handshake/status bundle between the Lynx reset sequencer and its surroundings.
//   i_pll_locked  : async, low requests reset
//   i_req         : async level reset requests, active-high
//   i_mode        : machine-mode word, any change can request reset
//   i_mode_chg_en : 1 = a mode change triggers reset
//   i_cause_clr   : sync pulse, clears the sticky cause record
//   o_rst_out     : per-domain reset, active-high, bit k released k-th
//   o_busy        : 1 while any o_rst_out bit is high
//   o_cause       : sticky cause record {mode change, pll unlock, req[NSRC-1:0]}
// master drives the inputs of the sequencer; slave is the sequencer side.
interface lynx_reset_sequencer_if #(
    parameter int unsigned NSRC   = 3,
    parameter int unsigned MODE_W = 2,
    parameter int unsigned NSTAGE = 2
) ();
    logic                i_pll_locked;
    logic [NSRC-1:0]     i_req;
    logic [MODE_W-1:0]   i_mode;
    logic                i_mode_chg_en;
    logic                i_cause_clr;
    logic [NSTAGE-1:0]   o_rst_out;
    logic                o_busy;
    logic [NSRC+1:0]     o_cause;

    modport master (
        output i_pll_locked, i_req, i_mode, i_mode_chg_en, i_cause_clr,
        input  o_rst_out, o_busy, o_cause
    );

    modport slave (
        input  i_pll_locked, i_req, i_mode, i_mode_chg_en, i_cause_clr,
        output o_rst_out, o_busy, o_cause
    );
endinterface

// File: rtl/lynx_reset_sequencer.sv
// Reset controller for the Lynx core top level. Gathers reset requests, PLL lock and
// machine-mode changes, stretches the reset to a minimum width and then releases NSTAGE
// reset domains in ascending order with a fixed gap. Keeps a sticky per-cause record.
// Ports:
//   i_clk_sys : system clock, all logic on the rising edge
//   i_reset_n : synchronous active-low global reset
//   bus       : slave side of lynx_reset_sequencer_if (requests in, rst_out/busy/cause out)
module lynx_reset_sequencer #(
    parameter int unsigned NSRC        = 3,
    parameter int unsigned MODE_W      = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STRETCH     = 16,
    parameter int unsigned NSTAGE      = 2,
    parameter int unsigned STAGE_GAP   = 8
) (
    input  logic                   i_clk_sys,
    input  logic                   i_reset_n,
    lynx_reset_sequencer_if.slave  bus
);

    localparam int unsigned CNT_MAX = (STRETCH > STAGE_GAP) ? STRETCH : STAGE_GAP;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned SW      = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

    localparam logic [CW-1:0] C_ONE     = CW'(1);
    localparam logic [CW-1:0] C_STRETCH = CW'(STRETCH);
    localparam logic [CW-1:0] C_GAP     = CW'(STAGE_GAP);
    localparam logic [SW-1:0] C_LAST    = SW'(NSTAGE - 1);
    localparam logic [SW-1:0] C_FIRST   = SW'(1);

    typedef enum logic [1:0] {
        S_HOLD,
        S_STRETCH,
        S_RELEASE,
        S_RUN
    } state_t;

    // Input synchronisers: shift toward the MSB, MSB is the synchronised value.
    logic [SYNC_STAGES-1:0]           r_pll_sync;
    logic [SYNC_STAGES-1:0][NSRC-1:0] r_req_sync;
    logic [MODE_W-1:0]                r_mode_q;
    logic                             r_mode_evt;
    logic [NSRC+1:0]                  r_cause;

    state_t                           r_state;
    logic [CW-1:0]                    r_cnt;
    logic [SW-1:0]                    r_stage;
    logic [NSTAGE-1:0]                r_rst_out;

    logic                             w_pll_s;
    logic [NSRC-1:0]                  w_req_s;
    logic                             w_any_req;

    state_t                           w_state_nxt;
    logic [CW-1:0]                    w_cnt_nxt;
    logic [SW-1:0]                    w_stage_nxt;
    logic [NSTAGE-1:0]                w_rst_nxt;

    assign w_pll_s   = r_pll_sync[SYNC_STAGES-1];
    assign w_req_s   = r_req_sync[SYNC_STAGES-1];
    assign w_any_req = (|w_req_s) | ~w_pll_s | r_mode_evt;

    // Synchronisers and mode tracking. mode_q follows mode even in reset so leaving
    // reset never produces a spurious mode event. The event itself is registered,
    // giving a two-edge mode-change-to-reset latency and keeping inputs off outputs.
    always_ff @(posedge i_clk_sys) begin
        r_mode_q <= bus.i_mode;
        if (!i_reset_n) begin
            r_pll_sync <= '0;
            r_req_sync <= '0;
            r_mode_evt <= 1'b0;
        end else begin
            r_pll_sync <= {r_pll_sync[SYNC_STAGES-2:0], bus.i_pll_locked};
            r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], bus.i_req};
            r_mode_evt <= bus.i_mode_chg_en & (bus.i_mode != r_mode_q);
        end
    end

    // Sticky cause record: a clear pulse loses to any source still active.
    always_ff @(posedge i_clk_sys) begin
        if (!i_reset_n) begin
            r_cause <= '0;
        end else begin
            r_cause <= (bus.i_cause_clr ? '0 : r_cause) | {r_mode_evt, ~w_pll_s, w_req_s};
        end
    end

    // FSM state register with registered outputs.
    always_ff @(posedge i_clk_sys) begin
        if (!i_reset_n) begin
            r_state   <= S_HOLD;
            r_cnt     <= '0;
            r_stage   <= '0;
            r_rst_out <= '1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_stage   <= w_stage_nxt;
            r_rst_out <= w_rst_nxt;
        end
    end

    // Next-state logic. Any request outside HOLD re-asserts every domain and restarts
    // the full stretch; r_stage holds the index of the next bit to release.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stage_nxt = r_stage;
        w_rst_nxt   = r_rst_out;

        if (w_any_req) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
            w_stage_nxt = '0;
            w_rst_nxt   = '1;
        end else begin
            case (r_state)
                S_HOLD: begin
                    w_state_nxt = S_STRETCH;
                    w_cnt_nxt   = C_ONE;
                    w_rst_nxt   = '1;
                end
                S_STRETCH: begin
                    if (r_cnt == C_STRETCH) begin
                        w_rst_nxt[0] = 1'b0;
                        if (NSTAGE == 1) begin
                            w_state_nxt = S_RUN;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = S_RELEASE;
                            w_cnt_nxt   = C_ONE;
                            w_stage_nxt = C_FIRST;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + C_ONE;
                    end
                end
                S_RELEASE: begin
                    if (r_cnt == C_GAP) begin
                        w_rst_nxt[r_stage] = 1'b0;
                        if (r_stage == C_LAST) begin
                            w_state_nxt = S_RUN;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_stage_nxt = r_stage + C_FIRST;
                            w_cnt_nxt   = C_ONE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + C_ONE;
                    end
                end
                S_RUN: begin
                    w_rst_nxt = '0;
                end
                default: begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                    w_stage_nxt = '0;
                    w_rst_nxt   = '1;
                end
            endcase
        end
    end

    assign bus.o_rst_out = r_rst_out;
    assign bus.o_busy    = |r_rst_out;
    assign bus.o_cause   = r_cause;

endmodule

// File: tb/tb_lynx_reset_sequencer.sv
// Directed bench for lynx_reset_sequencer: expected rst_out/busy/cause values are queued
// per cycle by the stimulus and compared on the falling edge by the monitor.
module tb_lynx_reset_sequencer;

    localparam int unsigned NSRC   = 3;
    localparam int unsigned MODE_W = 2;
    localparam int unsigned SYNC   = 2;
    localparam int unsigned STR    = 16;
    localparam int unsigned NSTAGE = 2;
    localparam int unsigned GAP    = 8;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    lynx_reset_sequencer_if #(.NSRC(NSRC), .MODE_W(MODE_W), .NSTAGE(NSTAGE)) bus ();

    lynx_reset_sequencer #(
        .NSRC(NSRC), .MODE_W(MODE_W), .SYNC_STAGES(SYNC),
        .STRETCH(STR), .NSTAGE(NSTAGE), .STAGE_GAP(GAP)
    ) dut (
        .i_clk_sys (clk),
        .i_reset_n (reset_n),
        .bus       (bus)
    );

    typedef struct {
        int unsigned cyc;
        logic [4:0]  val;
        int          tid;
    } exp_t;

    exp_t q_rst[$];
    exp_t q_cause[$];
    exp_t q_cnt[$];

    int unsigned cyc = 0;
    int unsigned n_total = 0;
    int unsigned n_pass = 0;
    bit done = 1'b0;
    exp_t er, ec, en;

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
            #1;
        end
    endtask

    task automatic step_to(input int unsigned c);
        while (cyc < c) step(1);
    endtask

    task automatic exp_rst(input int unsigned from, input int unsigned to,
                           input logic [1:0] v, input int tid);
        for (int unsigned c = from; c <= to; c++) q_rst.push_back('{c, {3'b000, v}, tid});
    endtask

    task automatic exp_cause(input int unsigned c, input logic [4:0] v, input int tid);
        q_cause.push_back('{c, v, tid});
    endtask

    function automatic int unsigned seq_end(input int unsigned t);
        return t + STR + GAP + 3;
    endfunction

    // t is the edge where HOLD first sees no request; start is the first edge with both bits high.
    task automatic exp_seq(input int unsigned start, input int unsigned t, input int tid);
        exp_rst(start, t + STR - 1, 2'b11, tid);
        exp_rst(t + STR, t + STR + GAP - 1, 2'b10, tid);
        exp_rst(t + STR + GAP, seq_end(t), 2'b00, tid);
    endtask

    task automatic clear_cause(input int tid);
        bus.i_cause_clr = 1'b1;
        exp_cause(cyc + 1, 5'b00000, tid);
        step(1);
        bus.i_cause_clr = 1'b0;
    endtask

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) begin
        while (q_rst.size() != 0 && q_rst[0].cyc <= cyc) begin
            er = q_rst.pop_front();
            n_total++;
            assert (er.cyc == cyc && bus.o_rst_out === er.val[1:0]) n_pass++;
            else $error("FAIL rst_out t%0d cyc %0d: got %b want %b (due cyc %0d)",
                        er.tid, cyc, bus.o_rst_out, er.val[1:0], er.cyc);
            n_total++;
            assert (bus.o_busy === (er.val[1:0] != 2'b00)) n_pass++;
            else $error("FAIL busy t%0d cyc %0d: got %b want %b",
                        er.tid, cyc, bus.o_busy, (er.val[1:0] != 2'b00));
        end
        while (q_cause.size() != 0 && q_cause[0].cyc <= cyc) begin
            ec = q_cause.pop_front();
            n_total++;
            assert (ec.cyc == cyc && bus.o_cause === ec.val) n_pass++;
            else $error("FAIL cause t%0d cyc %0d: got %b want %b (due cyc %0d)",
                        ec.tid, cyc, bus.o_cause, ec.val, ec.cyc);
        end
        while (q_cnt.size() != 0 && q_cnt[0].cyc <= cyc) begin
            en = q_cnt.pop_front();
            n_total++;
            assert (en.cyc == cyc && 5'(dut.r_cnt) === en.val) n_pass++;
            else $error("FAIL cnt t%0d cyc %0d: got %0d want %0d",
                        en.tid, cyc, dut.r_cnt, en.val);
        end
        if (done) begin
            n_total++;
            assert (q_rst.size() == 0 && q_cause.size() == 0 && q_cnt.size() == 0) n_pass++;
            else $error("FAIL drain: got %0d/%0d/%0d pending want 0",
                        q_rst.size(), q_cause.size(), q_cnt.size());
            $display("%0d/%0d checks passed", n_pass, n_total);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        int unsigned c1;

        // 1: reset held three edges, then power-up sequence; pll path reads unlocked after reset
        reset_n           = 1'b0;
        bus.i_pll_locked  = 1'b1;
        bus.i_req         = '0;
        bus.i_mode        = '0;
        bus.i_mode_chg_en = 1'b1;
        bus.i_cause_clr   = 1'b0;
        exp_rst(1, 3, 2'b11, 1);
        exp_cause(1, 5'b00000, 1);
        exp_cause(3, 5'b00000, 1);
        step(3);
        reset_n = 1'b1;
        exp_seq(4, 6, 1);
        exp_cause(4, 5'b01000, 1);
        exp_cause(seq_end(6), 5'b01000, 1);
        step_to(seq_end(6));
        clear_cause(1);

        // 2: button request held 5 cycles in RUN
        c0 = cyc;
        bus.i_req = 3'b010;
        exp_rst(c0 + 1, c0 + 2, 2'b00, 2);
        exp_seq(c0 + 3, c0 + 8, 2);
        exp_cause(c0 + 2, 5'b00000, 2);
        exp_cause(c0 + 3, 5'b00010, 2);
        step(5);
        bus.i_req = 3'b000;
        step_to(seq_end(c0 + 8));
        clear_cause(2);

        // 3: mode change with and without mode_chg_en
        c0 = cyc;
        bus.i_mode = 2'd2;
        exp_rst(c0 + 1, c0 + 1, 2'b00, 3);
        exp_seq(c0 + 2, c0 + 3, 3);
        exp_cause(c0 + 1, 5'b00000, 3);
        exp_cause(c0 + 2, 5'b10000, 3);
        step_to(seq_end(c0 + 3));
        c1 = cyc;
        bus.i_mode_chg_en = 1'b0;
        bus.i_mode = 2'd1;
        exp_rst(c1 + 1, c1 + 6, 2'b00, 3);
        exp_cause(c1 + 2, 5'b10000, 3);
        exp_cause(c1 + 6, 5'b10000, 3);
        step(6);
        bus.i_mode_chg_en = 1'b1;
        clear_cause(3);

        // 4: re-entry while stage 1 is still held
        c0 = cyc;
        bus.i_req = 3'b100;
        exp_rst(c0 + 1, c0 + 2, 2'b00, 4);
        exp_rst(c0 + 3, c0 + 19, 2'b11, 4);
        exp_rst(c0 + 20, c0 + 22, 2'b10, 4);
        exp_seq(c0 + 23, c0 + 24, 4);
        exp_cause(c0 + 3, 5'b00100, 4);
        exp_cause(c0 + 23, 5'b00101, 4);
        step(1);
        bus.i_req = 3'b000;
        step_to(c0 + 20);
        bus.i_req = 3'b001;
        step(1);
        bus.i_req = 3'b000;
        step_to(seq_end(c0 + 24));
        clear_cause(4);

        // 5: PLL loss for 100 cycles, cause_clr during and after
        c0 = cyc;
        bus.i_pll_locked = 1'b0;
        exp_rst(c0 + 1, c0 + 2, 2'b00, 5);
        exp_seq(c0 + 3, c0 + 103, 5);
        exp_cause(c0 + 2, 5'b00000, 5);
        exp_cause(c0 + 3, 5'b01000, 5);
        exp_cause(c0 + 51, 5'b01000, 5);
        exp_cause(c0 + 111, 5'b00000, 5);
        step_to(c0 + 50);
        bus.i_cause_clr = 1'b1;
        step(1);
        bus.i_cause_clr = 1'b0;
        step_to(c0 + 100);
        bus.i_pll_locked = 1'b1;
        step_to(c0 + 110);
        bus.i_cause_clr = 1'b1;
        step(1);
        bus.i_cause_clr = 1'b0;
        step_to(seq_end(c0 + 103));

        // 6: reset_n mid-stretch at cnt=9, then a full power-up sequence
        c0 = cyc;
        bus.i_req = 3'b010;
        exp_rst(c0 + 1, c0 + 2, 2'b00, 6);
        exp_seq(c0 + 3, c0 + 18, 6);
        exp_cause(c0 + 12, 5'b00010, 6);
        exp_cause(c0 + 13, 5'b00000, 6);
        exp_cause(c0 + 16, 5'b01000, 6);
        q_cnt.push_back('{c0 + 12, 5'd9, 6});
        q_cnt.push_back('{c0 + 13, 5'd0, 6});
        step(1);
        bus.i_req = 3'b000;
        step_to(c0 + 12);
        reset_n = 1'b0;
        step_to(c0 + 15);
        reset_n = 1'b1;
        step_to(seq_end(c0 + 18));

        step(2);
        done = 1'b1;
    end

endmodule
